// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Digits are double-buffered (pending -> shadow) and swapped only at frame boundaries.
module display_scan_ctrl #(
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_data,
  input  logic [3:0]  upd_blank,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_ON    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        idx, idx_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              pend_full, pend_full_nxt;
  logic [15:0]       pend_data;
  logic [3:0]        pend_blank;
  logic [15:0]       shad_data, shad_data_nxt;
  logic [3:0]        shad_blank, shad_blank_nxt;
  logic [6:0]        seg_nxt;
  logic [3:0]        an_nxt;
  logic              xfer, frame_end, apply;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    cnt_nxt        = cnt;
    pend_full_nxt  = pend_full;
    shad_data_nxt  = shad_data;
    shad_blank_nxt = shad_blank;
    an_nxt         = 4'hF;
    seg_nxt        = 7'h7F;

    xfer      = upd_valid && upd_ready;
    frame_end = en && (state == SHOW) && (idx == 2'd3) && (cnt == LAST_ON);
    // Swapping while dark cannot tear, so OFF applies a pending update immediately.
    apply     = pend_full && (frame_end || (state == OFF));

    case (state)
      OFF: begin
        cnt_nxt = '0;
        idx_nxt = 2'd0;
        if (en) state_nxt = BLANK;
      end
      BLANK: begin
        if (cnt == LAST_BLANK) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      SHOW: begin
        if (cnt == LAST_ON) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = idx + 2'd1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = OFF;
    endcase

    if (!en) begin
      state_nxt = OFF;
      idx_nxt   = 2'd0;
      cnt_nxt   = '0;
    end

    if (apply) begin
      shad_data_nxt  = pend_data;
      shad_blank_nxt = pend_blank;
      pend_full_nxt  = 1'b0;
    end
    if (xfer) pend_full_nxt = 1'b1;

    // Outputs are registered from next-state values so anode and segments switch together.
    if ((state_nxt == SHOW) && !shad_blank_nxt[idx_nxt]) begin
      an_nxt          = 4'hF;
      an_nxt[idx_nxt] = 1'b0;
      seg_nxt         = seg_decode(shad_data_nxt[{idx_nxt, 2'b00} +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OFF;
      idx        <= 2'd0;
      cnt        <= '0;
      pend_full  <= 1'b0;
      upd_ready  <= 1'b1;
      shad_data  <= 16'h0000;
      shad_blank <= 4'hF;
      an         <= 4'hF;
      seg        <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      pend_full  <= pend_full_nxt;
      upd_ready  <= !pend_full_nxt;
      shad_data  <= shad_data_nxt;
      shad_blank <= shad_blank_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_done <= frame_end;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      pend_data  <= upd_data;
      pend_blank <= upd_blank;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios plus random traffic, every cycle
// compared against a frame-position model of the display.
module tb_display_scan_ctrl;

  localparam int ON = 4;
  localparam int BL = 2;
  localparam int SLOT = ON + BL;
  localparam int FR = 4 * SLOT;
  localparam logic [6:0] SEGTAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic        clk = 1'b0;
  logic        rst_n, en, upd_valid, upd_ready, frame_done;
  logic [15:0] upd_data;
  logic [3:0]  upd_blank, an;
  logic [6:0]  seg;

  int n_chk = 0;
  int n_fail = 0;

  // Model state: running flag, cycles since scanning started, buffers, handshake.
  bit          m_run;
  int          m_t;
  bit          m_pend_full;
  logic [15:0] m_pend_data, m_sh_data;
  logic [3:0]  m_pend_blank, m_sh_blank;
  bit          m_fd, m_ready, m_acc;

  display_scan_ctrl #(.ON_CYCLES(ON), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_data(upd_data), .upd_blank(upd_blank), .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    if (d > 4'd9) return 7'h3F;
    return SEGTAB[d];
  endfunction

  task automatic model_reset();
    m_run = 0; m_t = 0; m_pend_full = 0; m_sh_data = 16'h0; m_sh_blank = 4'hF;
    m_fd = 0; m_ready = 1; m_acc = 0;
  endtask

  task automatic check_outputs();
    logic [3:0] ea;
    logic [6:0] es;
    int pos, slot, w;
    ea = 4'hF;
    es = 7'h7F;
    if (m_run) begin
      pos  = m_t % FR;
      slot = pos / SLOT;
      w    = pos % SLOT;
      if (w >= BL && !m_sh_blank[slot]) begin
        ea[slot] = 1'b0;
        es = ref_seg(m_sh_data[slot*4 +: 4]);
      end
    end
    chk("an", 32'(an), 32'(ea));
    chk("seg", 32'(seg), 32'(es));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("upd_ready", 32'(upd_ready), 32'(m_ready));
  endtask

  // One clock: advance model with the inputs present at the edge, then compare.
  task automatic cyc();
    bit fe, apply;
    @(posedge clk);
    m_acc = upd_valid && m_ready;
    fe    = m_run && en && ((m_t % FR) == FR - 1);
    apply = m_pend_full && (fe || !m_run);
    if (apply) begin
      m_sh_data = m_pend_data; m_sh_blank = m_pend_blank; m_pend_full = 0;
    end
    if (m_acc) begin
      m_pend_data = upd_data; m_pend_blank = upd_blank; m_pend_full = 1;
    end
    m_fd = fe;
    if (!en) m_run = 0;
    else if (!m_run) begin m_run = 1; m_t = 0; end
    else m_t++;
    m_ready = !m_pend_full;
    #1;
    check_outputs();
    if (m_acc) upd_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_pos(input int p);
    bit ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (m_run && (m_t % FR) == p) begin ok = 1; break; end
      cyc();
    end
    chk("wait_pos", 32'(ok), 32'd1);
  endtask

  task automatic offer(input logic [15:0] d, input logic [3:0] b);
    upd_data = d; upd_blank = b; upd_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; upd_valid = 1'b0; upd_data = '0; upd_blank = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1; en = 1'b1;

    // Idle scanning with all digits blanked by reset
    run(50);
    // Plain update 4321
    offer(16'h4321, 4'h0);
    run(60);
    // Transfer aligned to the frame-end edge, then a second offer held off
    wait_pos(FR - 1);
    offer(16'h1234, 4'h0);
    cyc();
    chk("xfer_at_frame_end", 32'(m_acc), 32'd1);
    offer(16'h5678, 4'h0);
    run(70);
    // Out-of-range codes and a blanked digit
    offer(16'hA0F9, 4'b0010);
    run(60);
    // Enable dropped mid-SHOW of digit 2 with an update pending
    wait_pos(0);
    offer(16'h9876, 4'h0);
    cyc();
    wait_pos(2 * SLOT + BL + 1);
    en = 1'b0;
    run(2);
    en = 1'b1;
    run(30);
    // Asynchronous reset mid-SHOW with pending data
    wait_pos(0);
    offer(16'h1111, 4'h0);
    cyc();
    wait_pos(SLOT + BL + 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    upd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    run(40);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 59) != 0);
      if (!upd_valid && $urandom_range(0, 3) == 0)
        offer(16'($urandom), 4'($urandom_range(0, 15)));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
